// File: rtl/rstatus_ctrl.sv
// $rstatus (r30) X->M->W commit pipe for overflow codes and setx, with forwarding and neq for bex.
// Latency: X request -> fwd next cycle, r30 write 2 cycles later, shadow updated 3 cycles later.
// Backpressure: stall holds M and sends a bubble to W. RSTATUS_OVF_CNT_EN enables a saturating ovf_count.
module rstatus_ctrl #(
    parameter int DATA_W      = 32,
    parameter int TARGET_W    = 27,
    parameter int RSTATUS_IDX = 30
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ovf_set,
    input  logic [DATA_W-1:0]   ovf_data,
    input  logic                setx_en,
    input  logic [TARGET_W-1:0] setx_target,
    input  logic                stall,
    input  logic                flush_x,
    input  logic                wb_we,
    input  logic [4:0]          wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                rstatus_we,
    output logic [DATA_W-1:0]   rstatus_wdata,
    output logic [DATA_W-1:0]   rstatus_fwd,
    output logic                neq,
    output logic [15:0]         ovf_count
);

    localparam logic [4:0] RS_IDX = 5'(RSTATUS_IDX);

    logic              m_valid_q, m_valid_d;
    logic              m_is_ovf_q, m_is_ovf_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              w_valid_q, w_valid_d;
    logic              w_is_ovf_q, w_is_ovf_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [DATA_W-1:0] rstatus_q, rstatus_d;
    logic              wb_hit;

    assign wb_hit        = wb_we && (wb_rd == RS_IDX);
    assign rstatus_we    = w_valid_q | wb_hit;
    assign rstatus_wdata = w_valid_q ? w_data_q : wb_data;

    always_comb begin
        if (m_valid_q)
            rstatus_fwd = m_data_q;
        else if (w_valid_q)
            rstatus_fwd = w_data_q;
        else if (wb_hit)
            rstatus_fwd = wb_data;
        else
            rstatus_fwd = rstatus_q;
    end

    assign neq = |rstatus_fwd;

    always_comb begin
        m_valid_d  = m_valid_q;
        m_is_ovf_d = m_is_ovf_q;
        m_data_d   = m_data_q;
        w_valid_d  = 1'b0;
        w_is_ovf_d = w_is_ovf_q;
        w_data_d   = w_data_q;
        rstatus_d  = rstatus_we ? rstatus_wdata : rstatus_q;
        // A stalled M entry stays put while W takes a bubble, so it commits exactly once.
        if (!stall) begin
            w_valid_d  = m_valid_q;
            w_is_ovf_d = m_is_ovf_q;
            w_data_d   = m_data_q;
            if (flush_x) begin
                m_valid_d = 1'b0;
            end else if (ovf_set) begin
                m_valid_d  = 1'b1;
                m_is_ovf_d = 1'b1;
                m_data_d   = ovf_data;
            end else if (setx_en) begin
                m_valid_d  = 1'b1;
                m_is_ovf_d = 1'b0;
                m_data_d   = {{(DATA_W-TARGET_W){1'b0}}, setx_target};
            end else begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q  <= 1'b0;
            m_is_ovf_q <= 1'b0;
            m_data_q   <= '0;
            w_valid_q  <= 1'b0;
            w_is_ovf_q <= 1'b0;
            w_data_q   <= '0;
            rstatus_q  <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_is_ovf_q <= m_is_ovf_d;
            m_data_q   <= m_data_d;
            w_valid_q  <= w_valid_d;
            w_is_ovf_q <= w_is_ovf_d;
            w_data_q   <= w_data_d;
            rstatus_q  <= rstatus_d;
        end
    end

`ifdef RSTATUS_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (w_valid_q && w_is_ovf_q && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ovf_cnt_q <= '0;
        else
            ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_rstatus_ctrl.sv
// Directed bench for rstatus_ctrl: commit latency, priority, stall/flush, reset, overflow counter.
module tb_rstatus_ctrl;

`ifdef RSTATUS_OVF_CNT_EN
    localparam logic [15:0] CNT_MASK = 16'hFFFF;
`else
    localparam logic [15:0] CNT_MASK = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ovf_set;
    logic [31:0] ovf_data;
    logic        setx_en;
    logic [26:0] setx_target;
    logic        stall;
    logic        flush_x;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rstatus_we;
    logic [31:0] rstatus_wdata;
    logic [31:0] rstatus_fwd;
    logic        neq;
    logic [15:0] ovf_count;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clock = ~clock;

    rstatus_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ovf_set      (ovf_set),
        .ovf_data     (ovf_data),
        .setx_en      (setx_en),
        .setx_target  (setx_target),
        .stall        (stall),
        .flush_x      (flush_x),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .rstatus_we   (rstatus_we),
        .rstatus_wdata(rstatus_wdata),
        .rstatus_fwd  (rstatus_fwd),
        .neq          (neq),
        .ovf_count    (ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ovf_set = 0; ovf_data = '0; setx_en = 0; setx_target = '0;
        stall = 0; flush_x = 0; wb_we = 0; wb_rd = '0; wb_data = '0;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic count_we(input int n);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (rstatus_we) pulses++;
            cyc();
        end
    endtask

    initial begin
        idle();
        reset_n = 0;
        #12;
        chk("rst_we", {31'b0, rstatus_we}, 32'd0);
        chk("rst_fwd", rstatus_fwd, 32'd0);
        chk("rst_neq", {31'b0, neq}, 32'd0);
        chk("rst_cnt", {16'b0, ovf_count}, 32'd0);
        reset_n = 1;
        cyc();

        // Overflow commit latency
        ovf_set = 1; ovf_data = 32'd2; #1;
        chk("ovf_c0_fwd", rstatus_fwd, 32'd0);
        cyc(); idle(); #1;
        chk("ovf_c1_neq", {31'b0, neq}, 32'd1);
        chk("ovf_c1_fwd", rstatus_fwd, 32'd2);
        chk("ovf_c1_we", {31'b0, rstatus_we}, 32'd0);
        cyc();
        chk("ovf_c2_we", {31'b0, rstatus_we}, 32'd1);
        chk("ovf_c2_wdata", rstatus_wdata, 32'd2);
        exp_cnt++;
        cyc();
        chk("ovf_c3_we", {31'b0, rstatus_we}, 32'd0);
        chk("ovf_c3_fwd", rstatus_fwd, 32'd2);

        // setx zero-extended commit
        setx_en = 1; setx_target = 27'h123;
        cyc(); idle(); cyc();
        chk("setx_we", {31'b0, rstatus_we}, 32'd1);
        chk("setx_wdata", rstatus_wdata, 32'h123);
        cyc();
        chk("setx_cnt", {16'b0, ovf_count}, {16'b0, exp_cnt & CNT_MASK});
        chk("setx_fwd", rstatus_fwd, 32'h123);

        // ovf and setx together: ovf wins
        ovf_set = 1; ovf_data = 32'd3; setx_en = 1; setx_target = 27'd5;
        cyc(); idle(); cyc();
        chk("conf_wdata", rstatus_wdata, 32'd3);
        exp_cnt++;
        cyc();

        // W slot beats a simultaneous normal r30 write
        setx_en = 1; setx_target = 27'd9;
        cyc(); idle(); cyc();
        wb_we = 1; wb_rd = 5'd30; wb_data = 32'd7; #1;
        chk("prio_we", {31'b0, rstatus_we}, 32'd1);
        chk("prio_wdata", rstatus_wdata, 32'd9);
        cyc(); idle(); #1;
        chk("prio_fwd", rstatus_fwd, 32'd9);

        // Normal r30 write forwards and commits; other indices ignored
        wb_we = 1; wb_rd = 5'd30; wb_data = 32'd7; #1;
        chk("wb_we", {31'b0, rstatus_we}, 32'd1);
        chk("wb_fwd", rstatus_fwd, 32'd7);
        cyc(); idle();
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'd55; #1;
        chk("wb0_we", {31'b0, rstatus_we}, 32'd0);
        chk("wb0_fwd", rstatus_fwd, 32'd7);
        wb_rd = 5'd29; #1;
        chk("wb29_we", {31'b0, rstatus_we}, 32'd0);
        cyc(); idle(); #1;
        chk("wb_commit_fwd", rstatus_fwd, 32'd7);

        // M entry forwards ahead of W entry
        ovf_set = 1; ovf_data = 32'd1;
        cyc(); idle();
        setx_en = 1; setx_target = 27'd4;
        cyc(); idle(); #1;
        chk("mw_fwd", rstatus_fwd, 32'd4);
        chk("mw_wdata", rstatus_wdata, 32'd1);
        exp_cnt++;
        cyc();
        chk("mw_w_wdata", rstatus_wdata, 32'd4);
        cyc();

        // Stall holds M for 3 cycles, then exactly one commit
        ovf_set = 1; ovf_data = 32'd2;
        cyc(); idle(); stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_we", {31'b0, rstatus_we}, 32'd0);
            chk("stall_fwd", rstatus_fwd, 32'd2);
            cyc();
        end
        stall = 0;
        count_we(5);
        chk("stall_pulses", pulses, 32'd1);
        exp_cnt++;
        chk("stall_cnt", {16'b0, ovf_count}, {16'b0, exp_cnt & CNT_MASK});

        // Flushed overflow never writes
        ovf_set = 1; ovf_data = 32'd3; flush_x = 1;
        cyc(); idle();
        count_we(4);
        chk("flush_pulses", pulses, 32'd0);
        chk("flush_fwd", rstatus_fwd, 32'd2);

        // Reset with both slots occupied
        ovf_set = 1; ovf_data = 32'd1;
        cyc(); ovf_data = 32'd3;
        cyc(); idle(); #1;
        chk("mid_we_pre", {31'b0, rstatus_we}, 32'd1);
        reset_n = 0; #1;
        chk("mid_rst_we", {31'b0, rstatus_we}, 32'd0);
        chk("mid_rst_fwd", rstatus_fwd, 32'd0);
        @(negedge clock);
        reset_n = 1;
        exp_cnt = 16'd0;
        cyc();
        count_we(4);
        chk("mid_pulses", pulses, 32'd0);
        chk("mid_fwd", rstatus_fwd, 32'd0);
        chk("mid_cnt", {16'b0, ovf_count}, 32'd0);

        // Three back-to-back overflow commits
        ovf_set = 1; ovf_data = 32'd1;
        for (int i = 0; i < 3; i++) cyc();
        idle();
        for (int i = 0; i < 3; i++) cyc();
        exp_cnt = 16'd3;
        chk("cnt3", {16'b0, ovf_count}, {16'b0, exp_cnt & CNT_MASK});

`ifdef RSTATUS_OVF_CNT_EN
        // Saturation: drive far more commits than the counter can hold
        ovf_set = 1; ovf_data = 32'd2;
        for (int i = 0; i < 65540; i++) cyc();
        idle();
        for (int i = 0; i < 3; i++) cyc();
        chk("cnt_sat", {16'b0, ovf_count}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
